// File: rtl/ct_ebiu_snoop_channel_pkg.sv
// ct_ebiu_snoop_channel_pkg: shared widths, FSM encoding and CR response layout
// for the EBIU snoop channel.
package ct_ebiu_snoop_channel_pkg;
    localparam int PA_WIDTH = 40;
    localparam int CD_DATAW = 128;
    localparam int ACID_W   = 5;
    localparam int CRRESP_W = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AC_REQ  = 3'd1,
        S_CR_WAIT = 3'd2,
        S_CR_OUT  = 3'd3,
        S_CD_XFER = 3'd4
    } snp_state_e;

    // Field order fixes the CRRESP bit indices: data_transfer is bit 0.
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } crresp_t;
endpackage

// File: rtl/ct_ebiu_snoop_cd_fifo.sv
// ct_ebiu_snoop_cd_fifo: 2-entry CD beat buffer; pointers and count reset
// asynchronously, storage is plain data flops.
module ct_ebiu_snoop_cd_fifo #(
    parameter int W = 129
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q, wr_d, rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q ^ push_i;
        rd_d  = rd_q ^ pop_i;
        cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = cnt_q == 2'd2;
    assign empty_o = cnt_q == 2'd0;
endmodule

// File: rtl/ct_ebiu_snoop_channel.sv
// ct_ebiu_snoop_channel: live ACE snoop path; one outstanding snoop from bus AC to
// ebiuif, CR response back to the bus, CD beats to the bus through a 2-entry buffer.
module ct_ebiu_snoop_channel
    import ct_ebiu_snoop_channel_pkg::*;
#(
    parameter int ADDRW = PA_WIDTH,
    parameter int DATAW = CD_DATAW
) (
    input  logic                cpuclk,
    input  logic                cpurst_b,
    input  logic                pad_ebiu_acvalid,
    input  logic [ADDRW-1:0]    pad_ebiu_acaddr,
    input  logic [2:0]          pad_ebiu_acprot,
    input  logic [3:0]          pad_ebiu_acsnoop,
    output logic                ebiu_pad_acready,
    output logic                ebiu_ebiuif_acvalid,
    output logic [ADDRW-1:0]    ebiu_ebiuif_acaddr,
    output logic [ACID_W-1:0]   ebiu_ebiuif_acid,
    output logic [2:0]          ebiu_ebiuif_acprot,
    output logic [3:0]          ebiu_ebiuif_acsnoop,
    input  logic                ebiuif_ebiu_ac_grant,
    output logic                ebiu_ebiuif_cr_grant,
    input  logic                ebiuif_ebiu_crvalid,
    input  logic [CRRESP_W-1:0] ebiuif_ebiu_crresp,
    output logic                ebiu_ebiuif_cd_grant,
    input  logic                ebiuif_ebiu_cdvalid,
    input  logic [DATAW-1:0]    ebiuif_ebiu_cddata,
    input  logic                ebiuif_ebiu_cdlast,
    output logic                ebiu_pad_crvalid,
    output logic [CRRESP_W-1:0] ebiu_pad_crresp,
    input  logic                pad_ebiu_crready,
    output logic                ebiu_pad_cdvalid,
    output logic [DATAW-1:0]    ebiu_pad_cddata,
    output logic                ebiu_pad_cdlast,
    input  logic                pad_ebiu_cdready,
    output logic                ebiu_snoop_channel_no_op
);
    snp_state_e        state_q, state_d;
    logic              acready_q;
    logic [ACID_W-1:0] acid_q, acid_d;
    logic [ADDRW-1:0]  addr_q, addr_d;
    logic [2:0]        prot_q, prot_d;
    logic [3:0]        snoop_q, snoop_d;
    crresp_t           crresp_q, crresp_d;
    logic              in_cd, fifo_full, fifo_empty, fifo_push, fifo_pop, head_last;
    logic [DATAW-1:0]  head_data;

    assign in_cd                    = state_q == S_CD_XFER;
    assign ebiu_pad_acready         = acready_q;
    assign ebiu_ebiuif_acvalid      = state_q == S_AC_REQ;
    assign ebiu_ebiuif_acaddr       = addr_q;
    assign ebiu_ebiuif_acid         = acid_q;
    assign ebiu_ebiuif_acprot       = prot_q;
    assign ebiu_ebiuif_acsnoop      = snoop_q;
    assign ebiu_ebiuif_cr_grant     = state_q == S_CR_WAIT;
    assign ebiu_pad_crvalid         = state_q == S_CR_OUT;
    assign ebiu_pad_crresp          = crresp_q;
    assign ebiu_ebiuif_cd_grant     = in_cd & ~fifo_full;
    assign ebiu_pad_cdvalid         = in_cd & ~fifo_empty;
    assign ebiu_pad_cddata          = head_data;
    assign ebiu_pad_cdlast          = ebiu_pad_cdvalid & head_last;
    assign fifo_push                = ebiuif_ebiu_cdvalid & ebiu_ebiuif_cd_grant;
    assign fifo_pop                 = ebiu_pad_cdvalid & pad_ebiu_cdready;
    assign ebiu_snoop_channel_no_op = (state_q == S_IDLE) & ~pad_ebiu_acvalid;

    always_comb begin
        state_d  = state_q;
        acid_d   = acid_q;
        addr_d   = addr_q;
        prot_d   = prot_q;
        snoop_d  = snoop_q;
        crresp_d = crresp_q;
        case (state_q)
            S_IDLE: if (pad_ebiu_acvalid && acready_q) begin
                state_d = S_AC_REQ;
                addr_d  = pad_ebiu_acaddr;
                prot_d  = pad_ebiu_acprot;
                snoop_d = pad_ebiu_acsnoop;
            end
            S_AC_REQ: if (ebiuif_ebiu_ac_grant) begin
                state_d = S_CR_WAIT;
                acid_d  = acid_q + 5'd1;
            end
            S_CR_WAIT: if (ebiuif_ebiu_crvalid) begin
                state_d  = S_CR_OUT;
                crresp_d = crresp_t'(ebiuif_ebiu_crresp);
            end
            S_CR_OUT: if (pad_ebiu_crready) state_d = crresp_q.data_transfer ? S_CD_XFER : S_IDLE;
            S_CD_XFER: if (fifo_pop && head_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= S_IDLE;
            acready_q <= 1'b0;
            acid_q    <= '0;
            addr_q    <= '0;
            prot_q    <= '0;
            snoop_q   <= '0;
            crresp_q  <= '0;
        end else begin
            state_q   <= state_d;
            acready_q <= state_d == S_IDLE;
            acid_q    <= acid_d;
            addr_q    <= addr_d;
            prot_q    <= prot_d;
            snoop_q   <= snoop_d;
            crresp_q  <= crresp_d;
        end
    end

    ct_ebiu_snoop_cd_fifo #(.W(DATAW + 1)) u_cd_fifo (
        .clk_i   (cpuclk),
        .rst_n_i (cpurst_b),
        .push_i  (fifo_push),
        .din_i   ({ebiuif_ebiu_cdlast, ebiuif_ebiu_cddata}),
        .pop_i   (fifo_pop),
        .dout_o  ({head_last, head_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
endmodule
